// File: rtl/led_cube_frame_scanner_if.sv
// led_cube_frame_scanner_if: received-byte stream from the UART path into the cube scanner
//   byte_in     8  received byte
//   byte_valid  1  one-cycle strobe, byte_in is new
// master drives the stream, slave (the scanner) consumes it.
interface led_cube_frame_scanner_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    modport master (output byte_in, byte_valid);
    modport slave  (input  byte_in, byte_valid);
endinterface

// File: rtl/led_cube_frame_scanner.sv
// led_cube_frame_scanner: double-buffered 8x8x8 LED cube frame receiver and layer scanner
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx             byte stream (slave modport): byte_in, byte_valid
//   Layers_out     one-hot layer enable
//   Latches_out    row latch clocks, at most one bit set
//   Data_out       column data bus shared by all row latches
//   frame_done     pulse when a new frame becomes the front buffer
//   frame_dropped  pulse when a start-of-frame is ignored because a swap is pending
//   rx_busy        high while a frame is being loaded
module led_cube_frame_scanner #(
    parameter logic [7:0] SOF_BYTE    = 8'hA5,
    parameter int         LATCH_HOLD  = 2,
    parameter int         LAYER_DWELL = 2000,
    parameter int         RX_TIMEOUT  = 50000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    led_cube_frame_scanner_if.slave       rx,
    output logic [7:0]                    Layers_out,
    output logic [7:0]                    Latches_out,
    output logic [7:0]                    Data_out,
    output logic                          frame_done,
    output logic                          frame_dropped,
    output logic                          rx_busy
);
    localparam int TMAX = LATCH_HOLD > LAYER_DWELL ? LATCH_HOLD : LAYER_DWELL;
    localparam int TW = $clog2(TMAX + 1);
    localparam int RW = $clog2(RX_TIMEOUT + 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(LATCH_HOLD - 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(LAYER_DWELL - 1);
    localparam logic [RW-1:0] RX_LAST    = RW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {S_BLANK, S_SETUP, S_STROBE, S_RELEASE, S_DISPLAY} scan_state_t;
    typedef enum logic {RX_IDLE, RX_LOAD} rx_state_t;

    scan_state_t     s, s_n;
    rx_state_t       rs, rs_n;
    logic [2:0]      layer, layer_n, row, row_n;
    logic [TW-1:0]   t, t_n;
    logic [5:0]      idx, idx_n;
    logic [RW-1:0]   rc, rc_n;
    logic            front, pending, t_last, swap, wr, last_byte;
    logic [7:0]      data_q;
    logic [7:0]      mem [2][64];

    always_comb begin
        t_last = t == (s == S_DISPLAY ? DWELL_LAST : HOLD_LAST);
        s_n = s;
        layer_n = layer;
        row_n = row;
        t_n = t + 1'b1;
        case (s)
            S_BLANK: begin
                s_n = S_SETUP;
                t_n = '0;
            end
            S_SETUP: if (t_last) begin
                s_n = S_STROBE;
                t_n = '0;
            end
            S_STROBE: if (t_last) begin
                s_n = S_RELEASE;
                t_n = '0;
            end
            S_RELEASE: begin
                // row 7 wraps to 0, which is exactly the row the next layer starts on
                t_n = '0;
                row_n = row + 3'd1;
                s_n = row == 3'd7 ? S_DISPLAY : S_SETUP;
            end
            S_DISPLAY: if (t_last) begin
                s_n = S_BLANK;
                t_n = '0;
                layer_n = layer + 3'd1;
            end
            default: begin
                s_n = S_BLANK;
                t_n = '0;
            end
        endcase
        // swap_pending is registered, so a final byte on the wrap cycle waits a full scan
        swap = s == S_DISPLAY && t_last && layer == 3'd7 && pending;
    end

    always_comb begin
        rs_n = rs;
        idx_n = idx;
        rc_n = rc + 1'b1;
        wr = 1'b0;
        last_byte = 1'b0;
        frame_dropped = 1'b0;
        case (rs)
            RX_IDLE: begin
                rc_n = '0;
                if (rx.byte_valid && rx.byte_in == SOF_BYTE) begin
                    frame_dropped = pending;
                    rs_n = pending ? RX_IDLE : RX_LOAD;
                    idx_n = '0;
                end
            end
            RX_LOAD: begin
                if (rx.byte_valid) begin
                    wr = 1'b1;
                    idx_n = idx + 6'd1;
                    rc_n = '0;
                    last_byte = idx == 6'd63;
                    rs_n = idx == 6'd63 ? RX_IDLE : RX_LOAD;
                end else if (rc == RX_LAST) begin
                    rs_n = RX_IDLE;
                end
            end
            default: rs_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= S_BLANK;
            layer <= '0;
            row <= '0;
            t <= '0;
            rs <= RX_IDLE;
            idx <= '0;
            rc <= '0;
            front <= 1'b0;
            pending <= 1'b0;
            data_q <= '0;
        end else begin
            s <= s_n;
            layer <= layer_n;
            row <= row_n;
            t <= t_n;
            rs <= rs_n;
            idx <= idx_n;
            rc <= rc_n;
            front <= front ^ swap;
            pending <= last_byte | (pending & ~swap);
            // entry to S_SETUP never coincides with a swap, so front is already settled
            if (s_n == S_SETUP) data_q <= mem[front][{layer_n, row_n}];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 64; j++)
                    mem[i][j] <= '0;
        end else if (wr) begin
            mem[!front][idx] <= rx.byte_in;
        end
    end

    assign Latches_out = s == S_STROBE ? 8'd1 << row : 8'd0;
    assign Layers_out  = s == S_DISPLAY ? 8'd1 << layer : 8'd0;
    assign Data_out    = data_q;
    assign frame_done  = swap;
    assign rx_busy     = rs == RX_LOAD;
endmodule
